// File: rtl/acc_adder_if.sv
// Operand/result bundle for acc_adder.
// The master drives the request side (en, mode, operands, clr_sticky);
// the slave (acc_adder) drives the registered result side.
interface acc_adder_if #(
   parameter int WIDTH = 4
);
   logic             en;
   logic [1:0]       mode;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic             clr_sticky;
   logic [WIDTH-1:0] Sum;
   logic             Overflow;
   logic             Valid;
   logic             Ovf_sticky;

   modport master (
      output en, mode, A, B, clr_sticky,
      input  Sum, Overflow, Valid, Ovf_sticky
   );

   modport slave (
      input  en, mode, A, B, clr_sticky,
      output Sum, Overflow, Valid, Ovf_sticky
   );
endinterface

// File: rtl/acc_adder.sv
// acc_adder: one-cycle add/subtract/accumulate unit with overflow detection
// and a sticky overflow flag. Sum doubles as the accumulator for ACC/DACC.
// Optional build macro ACC_ADDER_SAT_EN: clamp Sum on overflow instead of
// wrapping. Overflow/Ovf_sticky behave identically in both builds.
module acc_adder #(
   parameter int WIDTH  = 4,
   parameter bit SIGNED = 1'b0
) (
   input logic        clk,
   input logic        rst_n,
   acc_adder_if.slave bus
);

   typedef enum logic [1:0] {
      MODE_ADD  = 2'b00,
      MODE_SUB  = 2'b01,
      MODE_ACC  = 2'b10,
      MODE_DACC = 2'b11
   } mode_e;

   logic [WIDTH-1:0] r_sum;
   logic             r_ovf;
   logic             r_valid;
   logic             r_sticky;

   mode_e            w_mode;
   logic             w_use_acc;
   logic             w_is_sub;
   logic [WIDTH-1:0] w_lhs;
   logic [WIDTH-1:0] w_rhs;
   logic [WIDTH:0]   w_lhs_x;
   logic [WIDTH:0]   w_rhs_x;
   logic [WIDTH:0]   w_res_x;
   logic             w_ovf;
   logic [WIDTH-1:0] w_next_sum;
`ifdef ACC_ADDER_SAT_EN
   logic [WIDTH-1:0] w_sat;
`endif

   // Operand select and one-bit-wider arithmetic. The extra bit is the
   // carry/borrow for unsigned and the true sign for signed operation.
   always_comb begin
      w_mode    = mode_e'(bus.mode);
      w_use_acc = (w_mode == MODE_ACC) || (w_mode == MODE_DACC);
      w_is_sub  = (w_mode == MODE_SUB) || (w_mode == MODE_DACC);
      w_lhs     = w_use_acc ? r_sum : bus.A;
      w_rhs     = w_use_acc ? bus.A : bus.B;
      if (SIGNED) begin
         w_lhs_x = {w_lhs[WIDTH-1], w_lhs};
         w_rhs_x = {w_rhs[WIDTH-1], w_rhs};
      end else begin
         w_lhs_x = {1'b0, w_lhs};
         w_rhs_x = {1'b0, w_rhs};
      end
      w_res_x = w_is_sub ? (w_lhs_x - w_rhs_x) : (w_lhs_x + w_rhs_x);
      if (SIGNED) begin
         w_ovf = w_res_x[WIDTH] ^ w_res_x[WIDTH-1];
      end else begin
         w_ovf = w_res_x[WIDTH];
      end
   end

`ifdef ACC_ADDER_SAT_EN
   // Clamp value in the direction of the true result
   always_comb begin
      if (SIGNED) begin
         w_sat = w_res_x[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}}
                                : {1'b0, {(WIDTH-1){1'b1}}};
      end else begin
         w_sat = w_is_sub ? '0 : '1;
      end
      w_next_sum = w_ovf ? w_sat : w_res_x[WIDTH-1:0];
   end
`else
   // Wrapping result: true result modulo 2^WIDTH
   always_comb begin
      w_next_sum = w_res_x[WIDTH-1:0];
   end
`endif

   // Result, flag and sticky registers; a new overflow beats clr_sticky
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sum    <= '0;
         r_ovf    <= 1'b0;
         r_valid  <= 1'b0;
         r_sticky <= 1'b0;
      end else begin
         r_valid <= bus.en;
         if (bus.en) begin
            r_sum <= w_next_sum;
            r_ovf <= w_ovf;
         end
         if (bus.en && w_ovf) begin
            r_sticky <= 1'b1;
         end else if (bus.clr_sticky) begin
            r_sticky <= 1'b0;
         end
      end
   end

   assign bus.Sum        = r_sum;
   assign bus.Overflow   = r_ovf;
   assign bus.Valid      = r_valid;
   assign bus.Ovf_sticky = r_sticky;

endmodule

// File: tb/tb_acc_adder.sv
// Testbench for acc_adder (WIDTH=4): one unsigned and one signed instance
// share the same stimulus. Directed vector table, hand sequences for signed
// clamping and async reset, then random stimulus against an integer model.
module tb_acc_adder;

   localparam int W = 4;
`ifdef ACC_ADDER_SAT_EN
   localparam bit SAT = 1'b1;
`else
   localparam bit SAT = 1'b0;
`endif

   logic clk;
   logic rst_n;

   logic         t_en;
   logic [1:0]   t_mode;
   logic [W-1:0] t_a;
   logic [W-1:0] t_b;
   logic         t_clr;

   int n_checks = 0;
   int n_err    = 0;

   acc_adder_if #(.WIDTH(W)) if_u ();
   acc_adder_if #(.WIDTH(W)) if_s ();

   assign if_u.en = t_en;   assign if_s.en = t_en;
   assign if_u.mode = t_mode; assign if_s.mode = t_mode;
   assign if_u.A = t_a;     assign if_s.A = t_a;
   assign if_u.B = t_b;     assign if_s.B = t_b;
   assign if_u.clr_sticky = t_clr; assign if_s.clr_sticky = t_clr;

   acc_adder #(.WIDTH(W), .SIGNED(1'b0)) u_dut_u (.clk(clk), .rst_n(rst_n), .bus(if_u.slave));
   acc_adder #(.WIDTH(W), .SIGNED(1'b1)) u_dut_s (.clk(clk), .rst_n(rst_n), .bus(if_s.slave));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1);
   end

   // ---------------- reference model (index 0 unsigned, 1 signed) -------
   int m_sum[2];
   int m_ovf[2];
   int m_valid[2];
   int m_st[2];

   function automatic int as_int(int pattern, bit sgn);
      if (sgn && pattern >= (1 << (W-1))) return pattern - (1 << W);
      return pattern;
   endfunction

   task automatic model_reset();
      for (int s = 0; s < 2; s++) begin
         m_sum[s] = 0; m_ovf[s] = 0; m_valid[s] = 0; m_st[s] = 0;
      end
   endtask

   task automatic model_step();
      for (int s = 0; s < 2; s++) begin
         int l, r, t, lo, hi;
         bit ovf;
         bit sgn;
         sgn = (s == 1);
         if (t_en) begin
            l  = t_mode[1] ? as_int(m_sum[s], sgn) : as_int(int'(t_a), sgn);
            r  = t_mode[1] ? as_int(int'(t_a), sgn) : as_int(int'(t_b), sgn);
            t  = t_mode[0] ? (l - r) : (l + r);
            lo = sgn ? -(1 << (W-1)) : 0;
            hi = sgn ? (1 << (W-1)) - 1 : (1 << W) - 1;
            ovf = (t < lo) || (t > hi);
            if (ovf && SAT) t = (t > hi) ? hi : lo;
            m_sum[s]   = t & ((1 << W) - 1);
            m_ovf[s]   = ovf ? 1 : 0;
            m_valid[s] = 1;
            if (ovf) m_st[s] = 1;
            else if (t_clr) m_st[s] = 0;
         end else begin
            m_valid[s] = 0;
            if (t_clr) m_st[s] = 0;
         end
      end
   endtask

   // ---------------- checking helpers ----------------------------------
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   task automatic chk_model_u(input string tag);
      chk({tag, "_u_sum"},   32'(if_u.Sum),        32'(m_sum[0]));
      chk({tag, "_u_ovf"},   32'(if_u.Overflow),   32'(m_ovf[0]));
      chk({tag, "_u_valid"}, 32'(if_u.Valid),      32'(m_valid[0]));
      chk({tag, "_u_st"},    32'(if_u.Ovf_sticky), 32'(m_st[0]));
   endtask

   task automatic chk_model_s(input string tag);
      chk({tag, "_s_sum"},   32'(if_s.Sum),        32'(m_sum[1]));
      chk({tag, "_s_ovf"},   32'(if_s.Overflow),   32'(m_ovf[1]));
      chk({tag, "_s_valid"}, 32'(if_s.Valid),      32'(m_valid[1]));
      chk({tag, "_s_st"},    32'(if_s.Ovf_sticky), 32'(m_st[1]));
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_u_sum"},   32'(if_u.Sum),        0);
      chk({tag, "_u_ovf"},   32'(if_u.Overflow),   0);
      chk({tag, "_u_valid"}, 32'(if_u.Valid),      0);
      chk({tag, "_u_st"},    32'(if_u.Ovf_sticky), 0);
      chk({tag, "_s_sum"},   32'(if_s.Sum),        0);
      chk({tag, "_s_ovf"},   32'(if_s.Overflow),   0);
      chk({tag, "_s_valid"}, 32'(if_s.Valid),      0);
      chk({tag, "_s_st"},    32'(if_s.Ovf_sticky), 0);
   endtask

   task automatic set_in(input logic en, input logic [1:0] mode,
                         input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic clr);
      t_en = en; t_mode = mode; t_a = a; t_b = b; t_clr = clr;
   endtask

   // One clock: DUT samples at posedge, model follows, outputs checked #1 later
   task automatic cycle();
      @(posedge clk);
      model_step();
      #1;
   endtask

   // ---------------- directed vector table (unsigned instance) ---------
   typedef struct {
      logic         en;
      logic [1:0]   mode;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         clr;
      logic [W-1:0] sum_wrap;
      logic [W-1:0] sum_sat;
      logic         ovf;
      logic         valid;
      logic         st;
   } vec_t;

   vec_t vecs[17];

   initial begin
      vecs[0]  = '{1'b1, 2'b00, 4'd9,  4'd10, 1'b0, 4'd3,  4'd15, 1'b1, 1'b1, 1'b1};
      vecs[1]  = '{1'b1, 2'b01, 4'd3,  4'd5,  1'b0, 4'd14, 4'd0,  1'b1, 1'b1, 1'b1};
      vecs[2]  = '{1'b1, 2'b00, 4'd2,  4'd2,  1'b0, 4'd4,  4'd4,  1'b0, 1'b1, 1'b1};
      vecs[3]  = '{1'b0, 2'b10, 4'd5,  4'd0,  1'b1, 4'd4,  4'd4,  1'b0, 1'b0, 1'b0};
      vecs[4]  = '{1'b1, 2'b00, 4'd1,  4'd0,  1'b0, 4'd1,  4'd1,  1'b0, 1'b1, 1'b0};
      vecs[5]  = '{1'b1, 2'b10, 4'd3,  4'd9,  1'b0, 4'd4,  4'd4,  1'b0, 1'b1, 1'b0};
      vecs[6]  = '{1'b1, 2'b10, 4'd3,  4'd9,  1'b0, 4'd7,  4'd7,  1'b0, 1'b1, 1'b0};
      vecs[7]  = '{1'b1, 2'b10, 4'd3,  4'd9,  1'b0, 4'd10, 4'd10, 1'b0, 1'b1, 1'b0};
      vecs[8]  = '{1'b0, 2'b11, 4'd3,  4'd0,  1'b0, 4'd10, 4'd10, 1'b0, 1'b0, 1'b0};
      vecs[9]  = '{1'b1, 2'b10, 4'd7,  4'd0,  1'b1, 4'd1,  4'd15, 1'b1, 1'b1, 1'b1};
      vecs[10] = '{1'b1, 2'b00, 4'd0,  4'd0,  1'b0, 4'd0,  4'd0,  1'b0, 1'b1, 1'b1};
      vecs[11] = '{1'b1, 2'b11, 4'd1,  4'd6,  1'b0, 4'd15, 4'd0,  1'b1, 1'b1, 1'b1};
      vecs[12] = '{1'b1, 2'b00, 4'd5,  4'd3,  1'b1, 4'd8,  4'd8,  1'b0, 1'b1, 1'b0};
      vecs[13] = '{1'b1, 2'b01, 4'd5,  4'd5,  1'b0, 4'd0,  4'd0,  1'b0, 1'b1, 1'b0};
      vecs[14] = '{1'b1, 2'b00, 4'd15, 4'd0,  1'b0, 4'd15, 4'd15, 1'b0, 1'b1, 1'b0};
      vecs[15] = '{1'b1, 2'b00, 4'd15, 4'd1,  1'b0, 4'd0,  4'd15, 1'b1, 1'b1, 1'b1};
      vecs[16] = '{1'b0, 2'b01, 4'd0,  4'd0,  1'b0, 4'd0,  4'd15, 1'b1, 1'b0, 1'b1};

      set_in(1'b0, 2'b00, '0, '0, 1'b0);
      model_reset();
      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      #1;
      chk_all_zero("reset");
      #10 rst_n = 1'b1;   // released at t=12, away from the edge at t=15

      // Table phase
      for (int i = 0; i < 17; i++) begin
         set_in(vecs[i].en, vecs[i].mode, vecs[i].a, vecs[i].b, vecs[i].clr);
         cycle();
         chk($sformatf("vec%0d_sum", i),   32'(if_u.Sum),
             32'(SAT ? vecs[i].sum_sat : vecs[i].sum_wrap));
         chk($sformatf("vec%0d_ovf", i),   32'(if_u.Overflow),   32'(vecs[i].ovf));
         chk($sformatf("vec%0d_valid", i), 32'(if_u.Valid),      32'(vecs[i].valid));
         chk($sformatf("vec%0d_st", i),    32'(if_u.Ovf_sticky), 32'(vecs[i].st));
         chk_model_s($sformatf("vec%0d", i));
      end

      // Signed overflow and clamping on the signed instance
      set_in(1'b1, 2'b00, 4'd7, 4'd1, 1'b0);
      cycle();
      chk("s_add71_sum", 32'(if_s.Sum), SAT ? 32'd7 : 32'd8);
      chk("s_add71_ovf", 32'(if_s.Overflow), 1);
      chk_model_u("s_add71");
      set_in(1'b1, 2'b00, 4'd8, 4'd0, 1'b0);
      cycle();
      chk("s_min_sum", 32'(if_s.Sum), 8);
      chk("s_min_ovf", 32'(if_s.Overflow), 0);
      set_in(1'b1, 2'b11, 4'd1, 4'd0, 1'b0);
      cycle();
      chk("s_dacc_sum", 32'(if_s.Sum), SAT ? 32'd8 : 32'd7);
      chk("s_dacc_ovf", 32'(if_s.Overflow), 1);
      chk("s_dacc_st",  32'(if_s.Ovf_sticky), 1);
      chk_model_u("s_dacc");

      // Async reset in the middle of an accumulation
      set_in(1'b1, 2'b00, 4'd1, 4'd0, 1'b0);
      cycle();
      set_in(1'b1, 2'b10, 4'd3, 4'd0, 1'b0);
      cycle();
      cycle();
      chk("pre_rst_sum", 32'(if_u.Sum), 7);
      #2 rst_n = 1'b0;
      #1;
      chk_all_zero("async_rst");
      model_reset();
      @(posedge clk);
      #1;
      chk_all_zero("rst_held");
      #2 rst_n = 1'b1;
      set_in(1'b1, 2'b10, 4'd2, 4'd0, 1'b0);
      cycle();
      chk("post_rst_acc_sum",   32'(if_u.Sum), 2);
      chk("post_rst_acc_valid", 32'(if_u.Valid), 1);
      chk_model_u("post_rst");
      chk_model_s("post_rst");

      // Random stimulus against the model
      for (int i = 0; i < 400; i++) begin
         set_in(($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
                4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                ($urandom_range(0, 4) == 0));
         cycle();
         chk_model_u("rnd");
         chk_model_s("rnd");
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
      $finish;
   end

endmodule

// File: doc/acc_adder.md
ACC_ADDER -- requirements
Module: acc_adder

Interface
REQ-001 Parameter WIDTH, 4, operand/result width in bits (legal 2..32).
REQ-002 Parameter SIGNED, 0, 0 = unsigned arithmetic; 1 = two's-complement arithmetic.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 en  input  1  operation request, sampled every rising edge.
REQ-006 mode  input  2  operation select: 00 ADD, 01 SUB, 10 ACC, 11 DACC.
REQ-007 A  input  WIDTH  operand A.
REQ-008 B  input  WIDTH  operand B; ignored in ACC/DACC.
REQ-009 clr_sticky  input  1  clears Ovf_sticky.
REQ-010 Sum  output  WIDTH  registered result; also the accumulator.
REQ-011 Overflow  output  1  registered overflow of the result currently on Sum.
REQ-012 Valid  output  1  one-cycle pulse; Sum/Overflow updated this cycle.
REQ-013 Ovf_sticky  output  1  set by any overflowing operation, held until cleared.

Function
REQ-014 Operations SHALL be: ADD Sum<=A+B; SUB Sum<=A-B; ACC Sum<=Sum+A; DACC Sum<=Sum-A.
REQ-015 Latency SHALL be one cycle: en=1 at edge N -> Sum, Overflow updated and Valid=1 after edge N.
REQ-016 en=0 at an edge -> Sum, Overflow hold; Valid=0 after that edge.
REQ-017 Back-to-back en=1 SHALL be accepted every cycle; each ACC/DACC uses the Sum from the previous edge.
REQ-018 Unsigned overflow (SIGNED=0) SHALL be carry-out for ADD/ACC and borrow (subtrahend > minuend) for SUB/DACC.
REQ-019 Signed overflow (SIGNED=1) SHALL be asserted when the true result lies outside [-2^(WIDTH-1), 2^(WIDTH-1)-1].
REQ-020 Without saturation, Sum SHALL be the true result modulo 2^WIDTH.
REQ-021 Ovf_sticky SHALL set after any edge where en=1 and the result overflows; clr_sticky=1 clears it; on simultaneous set and clear, set wins.
REQ-022 clr_sticky SHALL NOT affect Sum, Overflow, or Valid.
REQ-023 mode SHALL be sampled only when en=1; mode changes while en=0 have no effect.

Reset
REQ-024 rst_n=0 SHALL immediately clear Sum=0, Overflow=0, Valid=0, Ovf_sticky=0, independent of clk.
REQ-025 Reset asserted mid-accumulation SHALL discard the accumulator; the first ACC after release SHALL compute 0+A.
REQ-026 The first rising edge with rst_n=1 SHALL perform a normal operation when en=1.

Configuration
REQ-027 Macro ACC_ADDER_SAT_EN defined: on overflow, Sum SHALL clamp. Unsigned: ADD/ACC -> 2^WIDTH-1; SUB/DACC -> 0. Signed: clamp to max positive or min negative, in the direction of the true result.
REQ-028 Macro ACC_ADDER_SAT_EN undefined: Sum SHALL wrap per REQ-020.
REQ-029 Overflow and Ovf_sticky behaviour SHALL be identical with and without ACC_ADDER_SAT_EN.

Verification (WIDTH=4)
REQ-030 SIGNED=0, ADD, A=9, B=10, en=1 -> next cycle Sum=3, Overflow=1, Valid=1, Ovf_sticky=1; with SAT_EN Sum=15.
REQ-031 SIGNED=0, SUB, A=3, B=5 -> Sum=14, Overflow=1; with SAT_EN Sum=0. Then ADD, A=2, B=2 -> Sum=4, Overflow=0, Ovf_sticky still 1.
REQ-032 ADD A=1, B=0, then ACC A=3 for three consecutive cycles -> Sum 1,4,7,10; Valid high four cycles. Then en=0 -> Sum holds 10, Valid=0.
REQ-033 SIGNED=1, ADD, A=7, B=1 -> Sum=4'b1000, Overflow=1; with SAT_EN Sum=4'b0111. DACC from Sum=-8 with A=1 -> Overflow=1; with SAT_EN Sum=-8.
REQ-034 Ovf_sticky=1; clr_sticky=1 with en=0 -> Ovf_sticky=0. clr_sticky=1 together with an overflowing op -> Ovf_sticky stays 1.
REQ-035 During an ACC sequence (Sum=7), drop rst_n between clock edges -> all outputs 0 immediately; after release, ACC A=2 -> Sum=2.
